// File: rtl/debug_state_seq.sv
// Capture-block debug sequencer: disarm, arm, poll for done, dump every entry
// to a ready/valid sink, then disarm again. One bus access outstanding at a time.
module debug_state_seq #(
   parameter int NUM_ENTRIES   = 255,
   parameter int POLL_INTERVAL = 16
) (
   input  logic        av_clk,
   input  logic        av_rst,
   input  logic        start,
   input  logic        abort,
   input  logic        force_trig,
   input  logic [7:0]  mode,
   output logic        busy,
   output logic        run_done,
   output logic [9:0]  m_address,
   output logic        m_write,
   output logic        m_read,
   output logic [31:0] m_writedata,
   input  logic [31:0] m_readdata,
   input  logic        m_readdatavalid,
   output logic [31:0] dump_data,
   output logic        dump_valid,
   input  logic        dump_ready,
   output logic        dump_last
);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_DISARM   = 4'd1;
   localparam logic [3:0] S_ARM      = 4'd2;
   localparam logic [3:0] S_WAIT     = 4'd3;
   localparam logic [3:0] S_POLL     = 4'd4;
   localparam logic [3:0] S_POLL_RSP = 4'd5;
   localparam logic [3:0] S_RD       = 4'd6;
   localparam logic [3:0] S_RD_RSP   = 4'd7;
   localparam logic [3:0] S_PUSH     = 4'd8;
   localparam logic [3:0] S_FINISH   = 4'd9;

   localparam logic [7:0]  LAST_ENTRY = 8'(NUM_ENTRIES);
   localparam logic [15:0] WAIT_LAST  = 16'(POLL_INTERVAL - 1);

   logic [3:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  entry_q, entry_d;
   logic [1:0]  word_q, word_d;
   logic [7:0]  mode_q, mode_d;
   logic        force_q, force_d;
   logic        abort_pend_q, abort_pend_d;
   logic [31:0] dump_data_q, dump_data_d;
   logic        last_word;

   assign last_word = (entry_q == LAST_ENTRY) && (word_q == 2'd3);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      entry_d      = entry_q;
      word_d       = word_q;
      mode_d       = mode_q;
      force_d      = force_q;
      abort_pend_d = abort_pend_q;
      dump_data_d  = dump_data_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d  = mode;
               force_d = force_trig;
               state_d = S_DISARM;
            end
         end
         S_DISARM: begin
            cnt_d   = 16'd0;
            state_d = S_ARM;
         end
         // ARM spends one quiet cycle first so the two writes are never back to back
         S_ARM: begin
            if (cnt_q[0]) begin
               cnt_d   = 16'd0;
               state_d = S_WAIT;
            end else begin
               cnt_d = 16'd1;
            end
         end
         S_WAIT: begin
            if (abort) begin
               state_d = S_FINISH;
            end else if (cnt_q == WAIT_LAST) begin
               cnt_d   = 16'd0;
               state_d = S_POLL;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_POLL: begin
            abort_pend_d = abort;
            state_d      = S_POLL_RSP;
         end
         // An abort seen while the poll is in flight waits for its response
         S_POLL_RSP: begin
            if (abort) abort_pend_d = 1'b1;
            if (m_readdatavalid) begin
               abort_pend_d = 1'b0;
               if (abort_pend_q || abort) begin
                  state_d = S_FINISH;
               end else if (m_readdata[2]) begin
                  entry_d = 8'd1;
                  word_d  = 2'd0;
                  state_d = S_RD;
               end else begin
                  cnt_d   = 16'd0;
                  state_d = S_WAIT;
               end
            end
         end
         S_RD: begin
            state_d = S_RD_RSP;
         end
         S_RD_RSP: begin
            if (m_readdatavalid) begin
               dump_data_d = m_readdata;
               state_d     = S_PUSH;
            end
         end
         S_PUSH: begin
            if (dump_ready) begin
               if (last_word) begin
                  state_d = S_FINISH;
               end else begin
                  word_d = word_q + 2'd1;
                  if (word_q == 2'd3) entry_d = entry_q + 8'd1;
                  state_d = S_RD;
               end
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge av_clk) begin
      if (av_rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= 16'd0;
         entry_q      <= 8'd0;
         word_q       <= 2'd0;
         mode_q       <= 8'd0;
         force_q      <= 1'b0;
         abort_pend_q <= 1'b0;
         dump_data_q  <= 32'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         entry_q      <= entry_d;
         word_q       <= word_d;
         mode_q       <= mode_d;
         force_q      <= force_d;
         abort_pend_q <= abort_pend_d;
         dump_data_q  <= dump_data_d;
      end
   end

   always_comb begin
      busy        = (state_q != S_IDLE);
      run_done    = (state_q == S_FINISH);
      m_address   = 10'd0;
      m_write     = 1'b0;
      m_read      = 1'b0;
      m_writedata = 32'd0;
      dump_valid  = 1'b0;
      dump_last   = 1'b0;
      case (state_q)
         S_DISARM: m_write = 1'b1;
         S_ARM: begin
            m_write     = cnt_q[0];
            m_writedata = cnt_q[0] ? {16'd0, mode_q, 6'd0, force_q, 1'b1} : 32'd0;
         end
         S_POLL: m_read = 1'b1;
         S_RD: begin
            m_read    = 1'b1;
            m_address = {entry_q, word_q};
         end
         S_PUSH: begin
            dump_valid = 1'b1;
            dump_last  = last_word;
         end
         S_FINISH: begin
            m_write     = 1'b1;
            m_writedata = {16'd0, mode_q, 8'd0};
         end
         default: ;
      endcase
   end

   assign dump_data = dump_data_q;

endmodule

// File: doc/debug_state_seq.md
DEBUG_STATE_SEQ -- requirements
Module: debug_state_seq

Interface
REQ-001 The parameter list SHALL be exactly:
- NUM_ENTRIES, 255, number of capture entries dumped per run (legal 1..255).
- POLL_INTERVAL, 16, idle clocks between status polls (legal 1..65535).
REQ-002 The port list SHALL be as follows, clock and reset first:
- av_clk  in  1  single clock for the whole block.
- av_rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle run request.
- abort  in  1  cancel run while polling.
- force  in  1  force-trigger value for the run.
- mode  in  8  capture mode for the run.
- busy  out  1  run in progress.
- run_done  out  1  one-cycle pulse at end of run, aborted or complete.
- m_address  out  10  capture block word address.
- m_write  out  1  write strobe.
- m_read  out  1  read strobe.
- m_writedata  out  32  write data.
- m_readdata  in  32  read data.
- m_readdatavalid  in  1  read data valid.
- dump_data  out  32  dumped word.
- dump_valid  out  1  dump word valid.
- dump_ready  in  1  sink accepts word.
- dump_last  out  1  final word of dump.

Function
REQ-003 The block SHALL sequence one capture run: disarm, arm, poll for done, dump entries, disarm.
REQ-004 The state machine SHALL have the states IDLE, DISARM, ARM, WAIT, POLL, POLL_RSP, RD, RD_RSP, PUSH and FINISH.
REQ-005 In IDLE, start=1 SHALL latch mode and force, set busy=1 on the next cycle and go to DISARM; start SHALL be ignored when busy=1.
REQ-006 DISARM SHALL assert m_write for one cycle with m_address=0 and m_writedata=0, which resets the capture write pointer, then go to ARM.
REQ-007 ARM SHALL assert m_write for one cycle with m_address=0 and m_writedata={16'd0, mode, 6'd0, force, 1'b1}.
REQ-008 WAIT SHALL count POLL_INTERVAL clocks and then go to POLL.
REQ-009 POLL SHALL assert m_read for exactly one cycle with m_address=0 and then go to POLL_RSP.
REQ-010 POLL_RSP SHALL wait for m_readdatavalid; if m_readdata[2]=1 it SHALL go to RD with the entry index set to 1, otherwise it SHALL go to WAIT.
REQ-011 Exactly one read SHALL be outstanding at any time; m_read SHALL NOT be reasserted before m_readdatavalid returns.
REQ-012 RD SHALL assert m_read for one cycle with m_address={entry[7:0], word[1:0]}, word running 0..3 (count, data0, data1, data2).
REQ-013 On m_readdatavalid, RD_RSP SHALL register m_readdata into dump_data and go to PUSH.
REQ-014 PUSH SHALL hold dump_valid=1 with dump_data stable until dump_ready=1.
REQ-015 On the dump_valid && dump_ready cycle, PUSH SHALL advance word; when word wraps from 3 to 0 it SHALL advance entry; it SHALL return to RD, or go to FINISH after the last word.
REQ-016 dump_last SHALL be 1 only on the word with entry=NUM_ENTRIES and word=3; a complete run SHALL output exactly 4*NUM_ENTRIES words.
REQ-017 FINISH SHALL write m_address=0 with m_writedata={16'd0, mode, 8'd0} (disarmed), pulse run_done for one cycle and clear busy on the next cycle, returning to IDLE.
REQ-018 abort=1 in WAIT SHALL go directly to FINISH.
REQ-019 abort=1 in POLL or POLL_RSP SHALL be held pending until the response returns, then SHALL go to FINISH.
REQ-020 abort SHALL be ignored in IDLE, DISARM, ARM, RD, RD_RSP and PUSH.
REQ-021 m_read and m_write SHALL never be high in the same cycle, and each SHALL be high for at most one consecutive cycle.
REQ-022 The POLL_INTERVAL counter SHALL be 16 bits; the entry counter SHALL be 8 bits and the word counter 2 bits.

Reset
REQ-023 While av_rst=1 at a rising av_clk, the block SHALL enter IDLE.
REQ-024 While av_rst=1 at a rising av_clk, busy, run_done, m_write, m_read, dump_valid and dump_last SHALL be 0, and m_address, m_writedata and dump_data SHALL be 0.
REQ-025 Reset mid-run SHALL abandon the run without a disarm write, and any late m_readdatavalid after reset SHALL be ignored.

Verification
REQ-026 Test: NUM_ENTRIES=2, start with mode=0x5A, force=1, slave done on the first poll -> writes 0x0 then 0x005A03, reads addr 0, then 4,5,6,7,8,9,10,11, 8 dump words with dump_last on the 8th, write 0x005A00, run_done pulse.
REQ-027 Test: status returns done=0 three times then done=1 with POLL_INTERVAL=4 -> exactly 4 status reads, at least 4 idle clocks between successive reads.
REQ-028 Test: dump_ready low for 10 cycles on word 2 -> dump_valid held, dump_data unchanged, no new m_read until accept.
REQ-029 Test: abort during WAIT -> next cycle FINISH, write 0x00mm00, run_done, no dump words; start while busy -> ignored.
REQ-030 Test: av_rst asserted in RD_RSP, then m_readdatavalid arrives -> all outputs 0, IDLE, no dump_valid.
REQ-031 Test: m_readdatavalid delayed 1..5 cycles randomly -> at most one outstanding read, word count and order correct.
